mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 62 ++++++
 rtl/mem_access_load_extract.sv | 41 ++++
 rtl/mem_access.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access stage: op bit positions,
// FSM state encoding, bus size codes and small op-decoding helpers.
package mem_access_pkg;

    // Bit positions inside the one-hot op vector {LB,LBU,LH,LHU,LW,SB,SH,SW}
    localparam int OP_W   = 8;
    localparam int OP_SW  = 0;
    localparam int OP_SH  = 1;
    localparam int OP_SB  = 2;
    localparam int OP_LW  = 3;
    localparam int OP_LHU = 4;
    localparam int OP_LH  = 5;
    localparam int OP_LBU = 6;
    localparam int OP_LB  = 7;

    // data_sram_size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Access FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } state_t;

    // Access width of an op; anything that is not a half or word op is a byte op
    function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
        logic [1:0] size;
        size = SIZE_BYTE;
        if (op[OP_LW] || op[OP_SW]) begin
            size = SIZE_WORD;
        end else if (op[OP_LH] || op[OP_LHU] || op[OP_SH]) begin
            size = SIZE_HALF;
        end
        return size;
    endfunction

    function automatic logic op_is_store(input logic [OP_W-1:0] op);
        return op[OP_SB] | op[OP_SH] | op[OP_SW];
    endfunction

    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return op[OP_LB] | op[OP_LH];
    endfunction

    // Halves must sit on even addresses, words on multiples of four
    function automatic logic is_misaligned(input logic [OP_W-1:0] op,
                                           input logic [1:0]      addr_lo);
        logic mis;
        case (op_size(op))
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = |addr_lo;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_load_extract.sv
// Picks the addressed byte/half out of the returned read word and extends it
// to 32 bits. Purely combinational; stores produce zero.
module mem_access_load_extract
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic        is_load,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection: byte by the low two address bits, half by address bit 1
    always_comb begin
        byte_sel = rdata[7:0];
        case (byte_off)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension to 32 bits; the word case passes the read data through
    always_comb begin
        result = '0;
        if (is_load) begin
            case (size)
                SIZE_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                SIZE_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
                default:   result = rdata;
            endcase
        end
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data memory access unit. Takes one load/store from EX, checks
// alignment, runs a single request/response transaction on the data SRAM
// bus and presents the (extended) load result or address exception.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a producer holding valid keeps its payload stable until then.
// in_valid/in_ready additionally require flush=0, because a flushed EX
// instruction is squashed. On the SRAM side data_sram_req/addr_ok form the
// address handshake; data_ok is a one-cycle response pulse.
module mem_access
    import mem_access_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [31:0]       address,
    input  logic [31:0]       store_data,
    input  logic              flush,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [31:0]       data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       load_result,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic [31:0]       bad_vaddr,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              addr_done_q, addr_done_d;
    logic [31:0]       load_result_q, load_result_d;
    logic              exc_adel_q, exc_adel_d;
    logic              exc_ades_q, exc_ades_d;
    logic [31:0]       bad_vaddr_q, bad_vaddr_d;

    logic              accept;
    logic              in_misaligned;
    logic              in_store;
    logic [31:0]       extract_result;

    assign in_misaligned = is_misaligned(op, address[1:0]);
    assign in_store      = op_is_store(op);
    assign accept        = in_valid && in_ready && !flush;

    mem_access_load_extract u_load_extract (
        .size     (op_size(op_q)),
        .sign_ext (op_is_signed(op_q)),
        .is_load  (!op_is_store(op_q)),
        .byte_off (addr_q[1:0]),
        .rdata    (data_sram_rdata),
        .result   (extract_result)
    );

    // State register; reset drops any in-flight transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = in_misaligned ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    state_d = ST_CANCEL;
                end else if (data_sram_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A flush coinciding with the response has nothing left to drain
                if (data_sram_data_ok) begin
                    state_d = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_d = ST_CANCEL;
                end
            end
            ST_DONE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    if (accept) begin
                        state_d = in_misaligned ? ST_DONE : ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CANCEL: begin
                // Only the response belonging to an already-accepted address counts
                if (addr_done_q && data_sram_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state and the latched instruction
    always_comb begin
        in_ready        = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid       = (state_q == ST_DONE);
        data_sram_req   = (state_q == ST_REQ) || ((state_q == ST_CANCEL) && !addr_done_q);
        data_sram_wr    = op_is_store(op_q);
        data_sram_size  = op_size(op_q);
        data_sram_addr  = addr_q;
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = data_q;
        case (op_size(op_q))
            SIZE_BYTE: begin
                data_sram_wstrb = 4'b0001 << addr_q[1:0];
                data_sram_wdata = {4{data_q[7:0]}};
            end
            SIZE_HALF: begin
                data_sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{data_q[15:0]}};
            end
            default: begin
                data_sram_wstrb = 4'b1111;
                data_sram_wdata = data_q;
            end
        endcase
        if (!op_is_store(op_q)) begin
            data_sram_wstrb = 4'b0000;
        end
        load_result = load_result_q;
        exc_adel    = exc_adel_q;
        exc_ades    = exc_ades_q;
        bad_vaddr   = bad_vaddr_q;
        dbg_state   = state_q;
    end

    // Next values for the latched instruction and the result registers
    always_comb begin
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        addr_done_d   = addr_done_q;
        load_result_d = load_result_q;
        exc_adel_d    = exc_adel_q;
        exc_ades_d    = exc_ades_q;
        bad_vaddr_d   = bad_vaddr_q;

        if (accept) begin
            op_d          = op;
            addr_d        = address;
            data_d        = store_data;
            addr_done_d   = 1'b0;
            load_result_d = '0;
            exc_adel_d    = in_misaligned && !in_store;
            exc_ades_d    = in_misaligned && in_store;
            bad_vaddr_d   = in_misaligned ? address : 32'h0;
        end

        // Remember an accepted address so a later cancel knows a response is owed
        if (((state_q == ST_REQ) || (state_q == ST_CANCEL)) && data_sram_req && data_sram_addr_ok) begin
            addr_done_d = 1'b1;
        end

        if ((state_q == ST_WAIT) && data_sram_data_ok && !flush) begin
            load_result_d = extract_result;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            addr_done_q   <= 1'b0;
            load_result_q <= '0;
            exc_adel_q    <= 1'b0;
            exc_ades_q    <= 1'b0;
            bad_vaddr_q   <= '0;
        end else begin
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            addr_done_q   <= addr_done_d;
            load_result_q <= load_result_d;
            exc_adel_q    <= exc_adel_d;
            exc_ades_q    <= exc_ades_d;
            bad_vaddr_q   <= bad_vaddr_d;
        end
    end

endmodule
